// File: rtl/rf_timing_pkg.sv
// Shared timing definitions for the RF dwell scheduler: sequencer states and
// default widths/timings.
package rf_timing_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int PULSE_W_DEF = 4;
    localparam int GUARD_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CT_UPD,
        CT_TRIG,
        CT_WAIT,
        RUN,
        DWELL_END
    } state_e;

    // A calibration slot opens the dwell that starts a new ct_every group.
    function automatic logic ct_due(input logic [7:0] ct_every, input logic [7:0] dwell_cnt);
        return (ct_every != 8'd0) && (dwell_cnt == 8'd0);
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Turns a one-cycle start strobe into a registered pulse PULSE_W cycles wide;
// clr_i kills a pulse in flight on the next edge.
module pulse_stretch #(
    parameter int PULSE_W = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic clr_i,
    output logic pulse_o
);

    localparam int CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        if (clr_i) begin
            cnt_d   = '0;
            pulse_d = 1'b0;
        end else if (start_i) begin
            cnt_d   = CW'(PULSE_W - 1);
            pulse_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/rf_dwell_scheduler.sv
// Dwell/CT-calibration timing master: sequences dwells of radar trig_1 pulses and
// interleaves AD9914 CT sweeps so a calibration window never overlaps a pulse.
module rf_dwell_scheduler
    import rf_timing_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PULSE_W = PULSE_W_DEF,
    parameter int GUARD   = GUARD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             abort,
    input  logic [CNT_W-1:0] prt,
    input  logic [15:0]      pulses_per_dwell,
    input  logic [7:0]       ct_every,
    input  logic [CNT_W-1:0] ct_period,
    output logic             ad9914_update_2,
    output logic             ad9914_trig_2,
    output logic             ad9914_trig_1,
    output logic             ct_active,
    output logic             busy,
    output logic             dwell_done
);

    localparam logic [CNT_W:0] CNT_ONE = (CNT_W + 1)'(1);

    logic rst_meta_q, rst_sync_q;

    state_e           state_q, state_d;
    logic [CNT_W:0]   cnt_q, cnt_d;       // one spare bit: ct_period+2+GUARD must not wrap
    logic [15:0]      pcnt_q, pcnt_d;
    logic [7:0]       dwell_cnt_q, dwell_cnt_d;
    logic             upd2_q, upd2_d, ct_act_q, ct_act_d, busy_q, busy_d, done_q, done_d;
    logic             trig1_start, trig2_start;
    logic [8:0]       dwell_inc;

    logic [CNT_W-1:0] prt_eff_q, ct_period_q;
    logic [15:0]      ppd_eff_q;
    logic [7:0]       ct_every_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign dwell_inc = {1'b0, dwell_cnt_q} + 9'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pcnt_d      = pcnt_q;
        dwell_cnt_d = dwell_cnt_q;
        trig1_start = 1'b0;
        trig2_start = 1'b0;
        if (abort) begin
            state_d     = IDLE;
            dwell_cnt_d = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: if (enable) state_d = LOAD;
                LOAD: begin
                    if (ct_due(ct_every, dwell_cnt_q)) begin
                        state_d = CT_UPD;
                    end else begin
                        state_d     = RUN;
                        cnt_d       = '0;
                        pcnt_d      = 16'd0;
                        trig1_start = 1'b1;
                    end
                end
                CT_UPD: begin
                    state_d     = CT_TRIG;
                    cnt_d       = (CNT_W + 1)'(PULSE_W - 1);
                    trig2_start = 1'b1;
                end
                CT_TRIG: begin
                    if (cnt_q == '0) begin
                        state_d = CT_WAIT;
                        cnt_d   = {1'b0, ct_period_q} + (CNT_W + 1)'(GUARD + 1);
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                CT_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d     = RUN;
                        cnt_d       = '0;
                        pcnt_d      = 16'd0;
                        trig1_start = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                RUN: begin
                    if (cnt_q == {1'b0, prt_eff_q - CNT_W'(1)}) begin
                        if (pcnt_q == ppd_eff_q - 16'd1) begin
                            state_d = DWELL_END;
                        end else begin
                            cnt_d       = '0;
                            pcnt_d      = pcnt_q + 16'd1;
                            trig1_start = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DWELL_END: begin
                    // >= so a ct_every lowered below the running count still wraps
                    dwell_cnt_d = (dwell_inc >= {1'b0, ct_every_q}) ? 8'd0 : dwell_inc[7:0];
                    state_d     = enable ? LOAD : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // Status flags are registered from the next state so they align with it.
        upd2_d   = (state_d == CT_UPD);
        ct_act_d = (state_d == CT_UPD) || (state_d == CT_TRIG) || (state_d == CT_WAIT);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DWELL_END);
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pcnt_q      <= 16'd0;
            dwell_cnt_q <= 8'd0;
            upd2_q      <= 1'b0;
            ct_act_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pcnt_q      <= pcnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            upd2_q      <= upd2_d;
            ct_act_q    <= ct_act_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Shadow configuration, captured only while in LOAD.
    always_ff @(posedge clk) begin
        if (state_q == LOAD) begin
            prt_eff_q   <= (prt < CNT_W'(PULSE_W + 1)) ? CNT_W'(PULSE_W + 1) : prt;
            ppd_eff_q   <= (pulses_per_dwell == 16'd0) ? 16'd1 : pulses_per_dwell;
            ct_every_q  <= ct_every;
            ct_period_q <= ct_period;
        end
    end

    pulse_stretch #(.PULSE_W(PULSE_W)) u_trig1 (
        .clk_i   (clk),
        .rst_ni  (rst_sync_q),
        .start_i (trig1_start),
        .clr_i   (abort),
        .pulse_o (ad9914_trig_1)
    );

    pulse_stretch #(.PULSE_W(PULSE_W)) u_trig2 (
        .clk_i   (clk),
        .rst_ni  (rst_sync_q),
        .start_i (trig2_start),
        .clr_i   (abort),
        .pulse_o (ad9914_trig_2)
    );

    assign ad9914_update_2 = upd2_q;
    assign ct_active       = ct_act_q;
    assign busy            = busy_q;
    assign dwell_done      = done_q;

endmodule
